// File: rtl/conv_window_gen_pkg.sv
// Shared convolver parameters: pixel width, frame size and kernel size used by
// the window generator, the multipliers and the adder tree.
package conv_window_gen_pkg;

    localparam int CONV_DATA_WIDTH = 16;
    localparam int CONV_IMG_WIDTH  = 28;
    localparam int CONV_KERNEL     = 5;
    localparam int CONV_TAPS       = CONV_KERNEL * CONV_KERNEL;

    // Flat tap number for window row r (0 = oldest) and column c (0 = oldest);
    // matches the adder tree's data_in_0..data_in_24 ordering.
    function automatic int tap_index(input int r, input int c);
        return r * CONV_KERNEL + c;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of pixel delay: the output is the pixel accepted DEPTH enables ago.
module line_buffer
    import conv_window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_DATA_WIDTH,
    parameter int DEPTH      = CONV_IMG_WIDTH
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic signed [DATA_WIDTH-1:0] dout
);

    logic signed [DATA_WIDTH-1:0] taps_p0 [DEPTH];

    // Contents are never reset: the frame counters keep stale entries out of valid windows.
    always_ff @(posedge clk) begin
        if (en) begin
            taps_p0[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps_p0[i] <= taps_p0[i-1];
            end
        end
    end

    assign dout = taps_p0[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// 5x5 sliding-window generator: turns a raster pixel stream into complete
// convolution windows (valid region only) behind a single output register.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_DATA_WIDTH,
    parameter int IMG_WIDTH  = CONV_IMG_WIDTH,
    parameter int KERNEL     = CONV_KERNEL
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic signed [DATA_WIDTH-1:0]          in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]   win_data
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int LB = KERNEL - 1;
    localparam logic [CW-1:0] LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] EDGE = CW'(KERNEL - 1);

    logic                         accept;
    logic                         completes;
    logic [CW-1:0]                col_p0;
    logic [CW-1:0]                row_p0;
    logic                         vld_p0;
    logic signed [DATA_WIDTH-1:0] win_p0  [KERNEL][KERNEL];
    logic signed [DATA_WIDTH-1:0] lb_in   [LB];
    logic signed [DATA_WIDTH-1:0] lb_out  [LB];
    logic signed [DATA_WIDTH-1:0] new_col [KERNEL];

    assign in_ready  = !vld_p0 || out_ready;
    assign accept    = in_valid && in_ready;
    assign completes = (row_p0 >= EDGE) && (col_p0 >= EDGE);
    assign out_valid = vld_p0;

    // Line buffer g holds the row g+1 above the incoming pixel.
    for (genvar g = 0; g < LB; g++) begin : g_line
        if (g == 0) begin : g_first
            assign lb_in[g] = in_data;
        end else begin : g_chain
            assign lb_in[g] = lb_out[g-1];
        end

        line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH)
        ) u_line_buffer (
            .clk  (clk),
            .en   (accept),
            .din  (lb_in[g]),
            .dout (lb_out[g])
        );
    end

    always_comb begin
        for (int r = 0; r < KERNEL - 1; r++) begin
            new_col[r] = lb_out[KERNEL-2-r];
        end
        new_col[KERNEL-1] = in_data;
    end

    // Stage p0: counters, window register and output valid update on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_p0 <= '0;
            row_p0 <= '0;
            vld_p0 <= 1'b0;
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    win_p0[r][c] <= '0;
                end
            end
        end else begin
            if (accept) begin
                vld_p0 <= completes;
                if (col_p0 == LAST) begin
                    col_p0 <= '0;
                    row_p0 <= (row_p0 == LAST) ? '0 : row_p0 + 1'b1;
                end else begin
                    col_p0 <= col_p0 + 1'b1;
                end
                for (int r = 0; r < KERNEL; r++) begin
                    for (int c = 0; c < KERNEL - 1; c++) begin
                        win_p0[r][c] <= win_p0[r][c+1];
                    end
                    win_p0[r][KERNEL-1] <= new_col[r];
                end
            end else if (out_ready) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                win_data[tap_index(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_p0[r][c];
            end
        end
    end

endmodule
